arp_cam_ctrl: RTL and testbench
===============================

Name: arp_cam_ctrl

Overview:
- Sequences and shares the single 48-bit MAC CAM used by the ARP attack detector.
- Two requesters:
  - check port: per-packet source-MAC lookup from the detector datapath.
  - learn port: trusted binding insertion from the management/register path.
- Initialises the CAM after reset and allocates write addresses (free fill, then round-robin replacement).
- Reports hit/miss per check and new/existing per learn.

Parameters:
- LUT_DEPTH_BITS, 4, CAM address width.
- LUT_DEPTH, 2**LUT_DEPTH_BITS, number of CAM entries.
- STARVE_LIMIT, 4, max consecutive check grants while a learn is pending.

Ports:
- clk  in  1  core clock.
- reset  in  1  reset, synchronous, active-high.
- chk_req  in  1  check request; hold with chk_mac until chk_ack.
- chk_mac  in  48  MAC to look up.
- chk_ack  out  1  one-cycle grant of check request.
- chk_done  out  1  one-cycle result strobe.
- chk_hit  out  1  valid with chk_done; 1 = MAC present.
- chk_addr  out  LUT_DEPTH_BITS  matching entry, valid with chk_done and chk_hit.
- lrn_req  in  1  learn request; hold with lrn_mac until lrn_ack.
- lrn_mac  in  48  MAC to insert.
- lrn_ack  out  1  one-cycle grant of learn request.
- lrn_done  out  1  one-cycle completion strobe.
- lrn_new  out  1  valid with lrn_done; 1 = entry written, 0 = already present or rejected.
- lrn_addr  out  LUT_DEPTH_BITS  entry written or matched.
- init_done  out  1  high once CAM clear has completed.
- entry_count  out  LUT_DEPTH_BITS+1  valid entries, saturating at LUT_DEPTH.
- cam_cmp_din  out  48  CAM compare data (registered).
- cam_match  in  1  CAM match, 1 cycle after cam_cmp_din.
- cam_match_addr  in  LUT_DEPTH_BITS  CAM match address.
- cam_busy  in  1  CAM write in progress.
- cam_din  out  48  CAM write data (registered).
- cam_we  out  1  CAM write enable, single-cycle pulse.
- cam_wr_addr  out  LUT_DEPTH_BITS  CAM write address (registered).

Behaviour:
- Reset values:
  - All strobes, acks, cam_we, init_done, entry_count, pointers and starvation counter = 0.
  - cam_din/cam_cmp_din = 0. State = INIT.
- Invalid MAC: 48'h0 marks an empty entry.
  - Check of 0: chk_done with chk_hit=0, no CAM compare.
  - Learn of 0: lrn_done with lrn_new=0, no write.
- FSM states: INIT, INIT_WAIT, IDLE, CMP, CMP_WAIT, RESULT, WR, WR_WAIT.
- INIT / INIT_WAIT:
  - Write 0 to addresses 0..LUT_DEPTH-1: one cam_we pulse, then wait until cam_busy low, minimum 2 cycles.
  - After the last entry, init_done=1 and go to IDLE.
  - No acks are issued before init_done.
- IDLE arbitration:
  - Check wins, unless lrn_req is pending and the starvation count == STARVE_LIMIT; then learn wins.
  - Starvation count: +1 on each check grant while lrn_req is high; cleared on learn grant or when lrn_req is low.
  - The winner's ack is high in the IDLE cycle N; its MAC is latched at the same edge.
- CMP (cycle N+1): cam_cmp_din = latched MAC.
- CMP_WAIT (cycle N+2): sample cam_match and cam_match_addr.
- RESULT (cycle N+3):
  - Check: chk_done=1 with chk_hit/chk_addr, then IDLE. Fixed check latency is 3 cycles from ack.
  - Learn with match: lrn_done=1, lrn_new=0, lrn_addr=match address.
  - Learn with miss: go to WR.
- WR:
  - cam_we=1 for one cycle; cam_din = MAC.
  - cam_wr_addr = free pointer if entry_count < LUT_DEPTH, else victim pointer.
- WR_WAIT:
  - Hold until cam_busy low, minimum 2 cycles.
  - Then lrn_done=1, lrn_new=1, lrn_addr = written address.
  - Free pointer and entry_count increment only when not full.
  - When full, the victim pointer increments, wrapping LUT_DEPTH-1 -> 0.
- Back-to-back operation: IDLE may grant in the cycle after any done strobe. Minimum spacing between acks is 4 cycles.
- Simultaneous chk_req and lrn_req: the arbitration rule above applies; the loser's req must stay asserted.
- A check issued after a learn's lrn_done sees the new entry.
- Reset mid-operation aborts the current operation with no done strobe and re-runs INIT; the CAM contents are cleared.

Decomposition:
- Shared package arp_defs_pkg:
  - State encoding constants.
  - MAC_W=48 and INVALID_MAC=48'h0.
  - CAM latency constants: CAM_RD_LAT=1, CAM_WR_LAT=2.
- One sub-module, arp_cam_alloc: free/victim pointers and entry_count, with an alloc request input and an address output.
- FSM and arbitration stay in arp_cam_ctrl.

Test Plan:
- Init: deassert reset -> exactly 16 cam_we pulses with cam_din=0 at addresses 0..15; init_done rises after the last; no acks before that.
- Learn then check: learn 0x0011_2233_4455 -> lrn_new=1, lrn_addr=0. Check the same MAC -> chk_done 3 cycles after chk_ack, chk_hit=1, chk_addr=0. Check 0x0011_2233_4456 -> chk_hit=0.
- Duplicate learn: learn 0x0011_2233_4455 twice -> second gives lrn_new=0, lrn_addr=0, no cam_we, entry_count stays 1.
- Full/wrap: learn 17 distinct MACs -> entry_count saturates at 16; 17th written at address 0 (victim), next victim is address 1.
- Starvation: hold chk_req and lrn_req continuously -> lrn_ack after exactly 4 chk_acks.
- Zero MAC and reset mid-op:
  - Check/learn of 48'h0 -> chk_hit=0 / lrn_new=0, no CAM activity.
  - Assert reset during WR_WAIT -> no lrn_done; INIT re-runs.

Source files
------------

// File: rtl/arp_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arp_defs_pkg
// Description : Shared constants for the ARP detector MAC CAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
package arp_defs_pkg;

  localparam int MAC_W      = 48;
  localparam logic [MAC_W-1:0] INVALID_MAC = '0;

  localparam int CAM_RD_LAT = 1;
  localparam int CAM_WR_LAT = 2;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_INIT      = 3'd0;
  localparam logic [STATE_W-1:0] S_INIT_WAIT = 3'd1;
  localparam logic [STATE_W-1:0] S_IDLE      = 3'd2;
  localparam logic [STATE_W-1:0] S_CMP       = 3'd3;
  localparam logic [STATE_W-1:0] S_CMP_WAIT  = 3'd4;
  localparam logic [STATE_W-1:0] S_RESULT    = 3'd5;
  localparam logic [STATE_W-1:0] S_WR        = 3'd6;
  localparam logic [STATE_W-1:0] S_WR_WAIT   = 3'd7;

endpackage
`default_nettype wire

// File: rtl/arp_cam_alloc.sv
`default_nettype none
// ============================================================================
// Module      : arp_cam_alloc
// Description : CAM write-address allocator: free fill, then round-robin victim.
// Revision    : 1.0 - initial release
// ============================================================================
module arp_cam_alloc #(
  parameter int LUT_DEPTH_BITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_alloc,
  output logic [LUT_DEPTH_BITS-1:0] o_alloc_addr,
  output logic [LUT_DEPTH_BITS:0]   o_entry_count
);

  localparam logic [LUT_DEPTH_BITS:0] c_full_count = {1'b1, {LUT_DEPTH_BITS{1'b0}}};

  logic [LUT_DEPTH_BITS-1:0] r_free_ptr;
  logic [LUT_DEPTH_BITS-1:0] r_victim_ptr;
  logic [LUT_DEPTH_BITS:0]   r_count;
  logic                      w_full;

  assign w_full        = (r_count == c_full_count);
  assign o_alloc_addr  = w_full ? r_victim_ptr : r_free_ptr;
  assign o_entry_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_free_ptr   <= '0;
      r_victim_ptr <= '0;
      r_count      <= '0;
    end else if (i_alloc) begin
      if (!w_full) begin
        r_free_ptr <= r_free_ptr + 1'b1;
        r_count    <= r_count + 1'b1;
      end else begin
        r_victim_ptr <= r_victim_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arp_cam_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arp_cam_ctrl
// Description : Clears, arbitrates and sequences the shared 48-bit MAC CAM.
// Revision    : 1.0 - initial release
// ============================================================================
module arp_cam_ctrl
  import arp_defs_pkg::*;
#(
  parameter int LUT_DEPTH_BITS = 4,
  parameter int LUT_DEPTH      = 2**LUT_DEPTH_BITS,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      chk_req,
  input  logic [MAC_W-1:0]          chk_mac,
  output logic                      chk_ack,
  output logic                      chk_done,
  output logic                      chk_hit,
  output logic [LUT_DEPTH_BITS-1:0] chk_addr,
  input  logic                      lrn_req,
  input  logic [MAC_W-1:0]          lrn_mac,
  output logic                      lrn_ack,
  output logic                      lrn_done,
  output logic                      lrn_new,
  output logic [LUT_DEPTH_BITS-1:0] lrn_addr,
  output logic                      init_done,
  output logic [LUT_DEPTH_BITS:0]   entry_count,
  output logic [MAC_W-1:0]          cam_cmp_din,
  input  logic                      cam_match,
  input  logic [LUT_DEPTH_BITS-1:0] cam_match_addr,
  input  logic                      cam_busy,
  output logic [MAC_W-1:0]          cam_din,
  output logic                      cam_we,
  output logic [LUT_DEPTH_BITS-1:0] cam_wr_addr
);

  localparam int c_stv_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] c_wait_min = 2'(CAM_WR_LAT - 1);

  logic [STATE_W-1:0]        r_state;
  logic [STATE_W-1:0]        w_next_state;
  logic [LUT_DEPTH_BITS-1:0] r_init_ptr;
  logic                      r_init_done;
  logic [1:0]                r_wait_cnt;
  logic [c_stv_w-1:0]        r_starve;
  logic [MAC_W-1:0]          r_mac;
  logic                      r_is_chk;
  logic                      r_zero;
  logic                      r_match;
  logic [LUT_DEPTH_BITS-1:0] r_match_addr;
  logic [MAC_W-1:0]          r_cmp_din;
  logic [MAC_W-1:0]          r_cam_din;
  logic                      r_cam_we;
  logic [LUT_DEPTH_BITS-1:0] r_cam_wr_addr;

  logic                      w_idle;
  logic                      w_lrn_prio;
  logic                      w_chk_gnt;
  logic                      w_lrn_gnt;
  logic [MAC_W-1:0]          w_gnt_mac;
  logic                      w_wait_ok;
  logic                      w_init_last;
  logic                      w_alloc;
  logic [LUT_DEPTH_BITS-1:0] w_alloc_addr;

  assign w_idle      = (r_state == S_IDLE) && r_init_done;
  assign w_lrn_prio  = lrn_req && (r_starve == c_stv_w'(STARVE_LIMIT));
  assign w_chk_gnt   = w_idle && chk_req && !w_lrn_prio;
  assign w_lrn_gnt   = w_idle && lrn_req && !w_chk_gnt;
  assign w_gnt_mac   = w_chk_gnt ? chk_mac : lrn_mac;
  // Write waits last at least CAM_WR_LAT cycles since cam_busy lags cam_we.
  assign w_wait_ok   = (r_wait_cnt == c_wait_min) && !cam_busy;
  assign w_init_last = (r_init_ptr == LUT_DEPTH_BITS'(LUT_DEPTH - 1));
  assign w_alloc     = (r_state == S_WR_WAIT) && w_wait_ok;

  arp_cam_alloc #(
    .LUT_DEPTH_BITS (LUT_DEPTH_BITS)
  ) u_alloc (
    .clk           (clk),
    .reset         (reset),
    .i_alloc       (w_alloc),
    .o_alloc_addr  (w_alloc_addr),
    .o_entry_count (entry_count)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT:      w_next_state = S_INIT_WAIT;
      S_INIT_WAIT: if (w_wait_ok) w_next_state = w_init_last ? S_IDLE : S_INIT;
      S_IDLE:      if (w_chk_gnt || w_lrn_gnt) w_next_state = S_CMP;
      S_CMP:       w_next_state = S_CMP_WAIT;
      S_CMP_WAIT:  w_next_state = S_RESULT;
      S_RESULT:    w_next_state = (r_is_chk || r_zero || r_match) ? S_IDLE : S_WR;
      S_WR:        w_next_state = S_WR_WAIT;
      S_WR_WAIT:   if (w_wait_ok) w_next_state = S_IDLE;
      default:     w_next_state = S_INIT;
    endcase
  end

  always_comb begin
    chk_ack  = w_chk_gnt;
    lrn_ack  = w_lrn_gnt;
    chk_done = (r_state == S_RESULT) && r_is_chk;
    chk_hit  = r_match;
    chk_addr = r_match_addr;
    lrn_done = ((r_state == S_RESULT) && !r_is_chk && (r_zero || r_match)) ||
               ((r_state == S_WR_WAIT) && w_wait_ok);
    lrn_new  = (r_state == S_WR_WAIT);
    lrn_addr = (r_state == S_WR_WAIT) ? r_cam_wr_addr : r_match_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_ptr    <= '0;
      r_init_done   <= 1'b0;
      r_wait_cnt    <= '0;
      r_starve      <= '0;
      r_mac         <= '0;
      r_is_chk      <= 1'b0;
      r_zero        <= 1'b0;
      r_match       <= 1'b0;
      r_match_addr  <= '0;
      r_cmp_din     <= '0;
      r_cam_din     <= '0;
      r_cam_we      <= 1'b0;
      r_cam_wr_addr <= '0;
    end else begin
      r_cam_we <= (r_state == S_INIT) || (r_state == S_WR);
      if (r_state == S_INIT) begin
        r_cam_din     <= INVALID_MAC;
        r_cam_wr_addr <= r_init_ptr;
      end
      if (r_state == S_WR) begin
        r_cam_din     <= r_mac;
        r_cam_wr_addr <= w_alloc_addr;
      end

      if ((r_state == S_INIT_WAIT) || (r_state == S_WR_WAIT)) begin
        if (r_wait_cnt != c_wait_min) r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      if ((r_state == S_INIT_WAIT) && w_wait_ok) begin
        if (w_init_last) r_init_done <= 1'b1;
        else             r_init_ptr  <= r_init_ptr + 1'b1;
      end

      // Zero MAC skips the compare bus so the CAM never sees an empty-entry key.
      if (w_chk_gnt || w_lrn_gnt) begin
        r_mac    <= w_gnt_mac;
        r_is_chk <= w_chk_gnt;
        r_zero   <= (w_gnt_mac == INVALID_MAC);
        if (w_gnt_mac != INVALID_MAC) r_cmp_din <= w_gnt_mac;
      end

      if (w_lrn_gnt || !lrn_req) r_starve <= '0;
      else if (w_chk_gnt)        r_starve <= r_starve + 1'b1;

      if (r_state == S_CMP_WAIT) begin
        r_match      <= cam_match && !r_zero;
        r_match_addr <= r_zero ? '0 : cam_match_addr;
      end
    end
  end

  assign init_done   = r_init_done;
  assign cam_cmp_din = r_cmp_din;
  assign cam_din     = r_cam_din;
  assign cam_we      = r_cam_we;
  assign cam_wr_addr = r_cam_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_arp_cam_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_arp_cam_ctrl
// Description : Self-checking bench for arp_cam_ctrl with a CAM model and a
//               table-based reference of the expected bindings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arp_cam_ctrl;

  localparam int c_depth = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chk_req = 1'b0;
  logic [47:0] chk_mac = '0;
  logic        lrn_req = 1'b0;
  logic [47:0] lrn_mac = '0;
  logic        chk_ack, chk_done, chk_hit, lrn_ack, lrn_done, lrn_new, init_done;
  logic [3:0]  chk_addr, lrn_addr, cam_wr_addr;
  logic [4:0]  entry_count;
  logic [47:0] cam_cmp_din, cam_din;
  logic        cam_we;
  logic        cam_match = 1'b0;
  logic [3:0]  cam_match_addr = '0;
  logic        cam_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  arp_cam_ctrl dut (
    .clk(clk), .reset(reset),
    .chk_req(chk_req), .chk_mac(chk_mac), .chk_ack(chk_ack), .chk_done(chk_done),
    .chk_hit(chk_hit), .chk_addr(chk_addr),
    .lrn_req(lrn_req), .lrn_mac(lrn_mac), .lrn_ack(lrn_ack), .lrn_done(lrn_done),
    .lrn_new(lrn_new), .lrn_addr(lrn_addr),
    .init_done(init_done), .entry_count(entry_count),
    .cam_cmp_din(cam_cmp_din), .cam_match(cam_match), .cam_match_addr(cam_match_addr),
    .cam_busy(cam_busy), .cam_din(cam_din), .cam_we(cam_we), .cam_wr_addr(cam_wr_addr)
  );

  // CAM model: stale contents while reset, 1-cycle compare, 2-cycle busy after a write.
  logic [47:0] cam_mem [c_depth];
  logic [1:0]  busy_sr = '0;
  logic        w_hit;
  logic [3:0]  w_hit_addr;

  assign cam_busy = |busy_sr;

  always_comb begin
    w_hit      = 1'b0;
    w_hit_addr = '0;
    for (int i = c_depth - 1; i >= 0; i--) begin
      if (cam_mem[i] == cam_cmp_din) begin
        w_hit      = 1'b1;
        w_hit_addr = 4'(i);
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_depth; i++) cam_mem[i] <= {16'hA5A5, 28'h0, 4'(i)};
      busy_sr <= '0;
    end else begin
      if (cam_we) cam_mem[cam_wr_addr] <= cam_din;
      busy_sr <= {busy_sr[0], cam_we};
    end
    cam_match      <= w_hit;
    cam_match_addr <= w_hit_addr;
  end

  int          we_cnt = 0;
  int          early_ack = 0;
  int          lrn_done_cnt = 0;
  logic [3:0]  we_addr_log [64];
  logic [47:0] we_din_log  [64];

  always @(posedge clk) begin
    if (!reset && cam_we) begin
      we_addr_log[we_cnt[5:0]] <= cam_wr_addr;
      we_din_log[we_cnt[5:0]]  <= cam_din;
      we_cnt <= we_cnt + 1;
    end
    if (!init_done && (chk_ack || lrn_ack)) early_ack <= early_ack + 1;
    if (!reset && lrn_done) lrn_done_cnt <= lrn_done_cnt + 1;
  end

  // Reference: binding table filled in order, then overwritten round-robin.
  logic [47:0] m_tab [c_depth];
  int          m_count;
  int          m_victim;
  logic [47:0] exp_cmp;

  function automatic void m_clear();
    for (int i = 0; i < c_depth; i++) m_tab[i] = '0;
    m_count  = 0;
    m_victim = 0;
  endfunction

  function automatic int m_find(input logic [47:0] mac);
    if (mac == 48'h0) return -1;
    for (int i = 0; i < m_count; i++) if (m_tab[i] == mac) return i;
    return -1;
  endfunction

  function automatic int m_insert(input logic [47:0] mac);
    int a;
    if (m_count < c_depth) begin
      a = m_count;
      m_count++;
    end else begin
      a = m_victim;
      m_victim = (m_victim + 1) % c_depth;
    end
    m_tab[a] = mac;
    return a;
  endfunction

  function automatic logic [47:0] rand_mac();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    return {8'h02, a[7:0], b};
  endfunction

  task automatic drv_chk(input logic [47:0] mac, output logic hit, output logic [3:0] addr,
                         output int lat);
    int n;
    hit = 1'b0; addr = '0; lat = -1; n = 0;
    chk_req = 1'b1; chk_mac = mac;
    do begin @(negedge clk); n++; end while (!chk_ack && n < 100);
    @(posedge clk); #1;
    chk_req = 1'b0;
    if (n >= 100) return;
    if (mac != 48'h0) exp_cmp = mac;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (chk_done) begin lat = k; hit = chk_hit; addr = chk_addr; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic drv_lrn(input logic [47:0] mac, output logic is_new, output logic [3:0] addr,
                         output int lat, output int we_delta);
    int n, b;
    is_new = 1'b0; addr = '0; lat = -1; n = 0; b = we_cnt;
    lrn_req = 1'b1; lrn_mac = mac;
    do begin @(negedge clk); n++; end while (!lrn_ack && n < 100);
    @(posedge clk); #1;
    lrn_req = 1'b0;
    if (n < 100) begin
      if (mac != 48'h0) exp_cmp = mac;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (lrn_done) begin lat = k; is_new = lrn_new; addr = lrn_addr; break; end
      end
      @(posedge clk); #1;
    end
    we_delta = we_cnt - b;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({chk_ack, lrn_ack, chk_done, lrn_done, cam_we, init_done} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes got=%b want=0",
                         {chk_ack, lrn_ack, chk_done, lrn_done, cam_we, init_done});
    end
    checks++;
    if (entry_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", entry_count); end
    checks++;
    if (cam_din !== 48'h0 || cam_cmp_din !== 48'h0) begin
      errors++; $display("FAIL reset_cam_data got din=%h cmp=%h want 0", cam_din, cam_cmp_din);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_init();
    int b, e0, n;
    b = we_cnt; e0 = early_ack; n = 0;
    chk_req = 1'b1; chk_mac = '0; lrn_req = 1'b1; lrn_mac = '0;
    do begin @(negedge clk); n++; end while (!init_done && n < 2000);
    chk_req = 1'b0; lrn_req = 1'b0;
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got=%b want=1", init_done); end
    checks++;
    if (we_cnt - b !== 16) begin errors++; $display("FAIL init_we_count got=%0d want=16", we_cnt - b); end
    checks++;
    if (early_ack !== e0) begin errors++; $display("FAIL init_early_ack got=%0d want=0", early_ack - e0); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (we_addr_log[6'(b + i)] !== 4'(i) || we_din_log[6'(b + i)] !== 48'h0) begin
        errors++;
        $display("FAIL init_write%0d got addr=%0d din=%h want addr=%0d din=0",
                 i, we_addr_log[6'(b + i)], we_din_log[6'(b + i)], i);
      end
    end
    checks++;
    if (entry_count !== 5'd0) begin errors++; $display("FAIL init_count got=%0d want=0", entry_count); end
    m_clear();
    exp_cmp = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_learn_check();
    logic nw, hit; logic [3:0] a; int lat, wd, ea;
    drv_lrn(48'h0011_2233_4455, nw, a, lat, wd);
    ea = m_insert(48'h0011_2233_4455);
    checks++;
    if (nw !== 1'b1 || a !== 4'(ea)) begin errors++; $display("FAIL learn1 got new=%b addr=%0d want new=1 addr=%0d", nw, a, ea); end
    checks++;
    if (wd !== 1 || we_din_log[6'(we_cnt - 1)] !== 48'h0011_2233_4455 || we_addr_log[6'(we_cnt - 1)] !== 4'(ea)) begin
      errors++; $display("FAIL learn1_write got we=%0d din=%h want we=1 din=001122334455", wd, we_din_log[6'(we_cnt - 1)]);
    end
    drv_chk(48'h0011_2233_4455, hit, a, lat);
    checks++;
    if (lat !== 3 || hit !== 1'b1 || a !== 4'(m_find(48'h0011_2233_4455))) begin
      errors++; $display("FAIL check_hit got lat=%0d hit=%b addr=%0d want lat=3 hit=1 addr=0", lat, hit, a);
    end
    drv_chk(48'h0011_2233_4456, hit, a, lat);
    checks++;
    if (lat !== 3 || hit !== 1'b0) begin errors++; $display("FAIL check_miss got lat=%0d hit=%b want lat=3 hit=0", lat, hit); end
    checks++;
    if (cam_cmp_din !== exp_cmp) begin errors++; $display("FAIL cmp_din got=%h want=%h", cam_cmp_din, exp_cmp); end
  endtask

  task automatic test_duplicate();
    logic nw; logic [3:0] a; int lat, wd;
    drv_lrn(48'h0011_2233_4455, nw, a, lat, wd);
    checks++;
    if (lat !== 3 || nw !== 1'b0 || a !== 4'(m_find(48'h0011_2233_4455)) || wd !== 0) begin
      errors++; $display("FAIL dup_learn got lat=%0d new=%b addr=%0d we=%0d want lat=3 new=0 addr=0 we=0", lat, nw, a, wd);
    end
    checks++;
    if (entry_count !== 5'(m_count)) begin errors++; $display("FAIL dup_count got=%0d want=%0d", entry_count, m_count); end
  endtask

  task automatic test_zero_mac();
    logic nw, hit; logic [3:0] a; int lat, wd;
    drv_chk(48'h0, hit, a, lat);
    checks++;
    if (lat !== 3 || hit !== 1'b0) begin errors++; $display("FAIL zero_check got lat=%0d hit=%b want lat=3 hit=0", lat, hit); end
    checks++;
    if (cam_cmp_din !== exp_cmp) begin errors++; $display("FAIL zero_cmp_din got=%h want=%h", cam_cmp_din, exp_cmp); end
    drv_lrn(48'h0, nw, a, lat, wd);
    checks++;
    if (lat < 0 || nw !== 1'b0 || wd !== 0) begin errors++; $display("FAIL zero_learn got lat=%0d new=%b we=%0d want new=0 we=0", lat, nw, wd); end
    checks++;
    if (entry_count !== 5'(m_count) || cam_cmp_din !== exp_cmp) begin
      errors++; $display("FAIL zero_learn_state got cnt=%0d cmp=%h want cnt=%0d cmp=%h", entry_count, cam_cmp_din, m_count, exp_cmp);
    end
  endtask

  task automatic test_starvation();
    int nchk, ea, lat; logic got, nw; logic [3:0] a; logic [47:0] mac;
    nchk = 0; got = 1'b0; lat = -1; nw = 1'b0; a = '0;
    mac = rand_mac();
    chk_req = 1'b1; chk_mac = 48'h0011_2233_4455; lrn_req = 1'b1; lrn_mac = mac;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (lrn_ack) begin got = 1'b1; break; end
      if (chk_ack) nchk++;
    end
    @(posedge clk); #1;
    chk_req = 1'b0; lrn_req = 1'b0;
    checks++;
    if (got !== 1'b1 || nchk !== 4) begin errors++; $display("FAIL starve_grants got lrn_ack=%b chk_acks=%0d want 1 and 4", got, nchk); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (lrn_done) begin lat = k; nw = lrn_new; a = lrn_addr; break; end
    end
    @(posedge clk); #1;
    ea = m_insert(mac);
    exp_cmp = mac;
    checks++;
    if (lat < 0 || nw !== 1'b1 || a !== 4'(ea)) begin errors++; $display("FAIL starve_learn got new=%b addr=%0d want new=1 addr=%0d", nw, a, ea); end
  endtask

  task automatic test_reset_midop();
    int n, d0, lat; logic hit; logic [3:0] a;
    n = 0;
    lrn_req = 1'b1; lrn_mac = rand_mac();
    do begin @(negedge clk); n++; end while (!lrn_ack && n < 100);
    @(posedge clk); #1;
    lrn_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!cam_we && n < 40);
    checks++;
    if (cam_we !== 1'b1) begin errors++; $display("FAIL midop_write got cam_we=%b want=1", cam_we); end
    d0 = lrn_done_cnt;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_init();
    checks++;
    if (lrn_done_cnt !== d0) begin errors++; $display("FAIL midop_done got=%0d want=%0d", lrn_done_cnt - d0, 0); end
    drv_chk(48'h0011_2233_4455, hit, a, lat);
    checks++;
    if (lat !== 3 || hit !== 1'b0) begin errors++; $display("FAIL midop_cleared got lat=%0d hit=%b want lat=3 hit=0", lat, hit); end
  endtask

  task automatic test_full_wrap();
    logic nw, hit; logic [3:0] a; int lat, wd, ea; logic [47:0] first, mac;
    first = '0;
    for (int i = 0; i < 18; i++) begin
      mac = rand_mac();
      if (i == 0) first = mac;
      drv_lrn(mac, nw, a, lat, wd);
      ea = m_insert(mac);
      checks++;
      if (nw !== 1'b1 || a !== 4'(ea) || wd !== 1) begin
        errors++; $display("FAIL fill%0d got new=%b addr=%0d we=%0d want new=1 addr=%0d we=1", i, nw, a, wd, ea);
      end
      checks++;
      if (entry_count !== 5'(m_count)) begin errors++; $display("FAIL fill%0d_count got=%0d want=%0d", i, entry_count, m_count); end
    end
    drv_chk(first, hit, a, lat);
    checks++;
    if (lat !== 3 || hit !== 1'b0) begin errors++; $display("FAIL evicted got lat=%0d hit=%b want lat=3 hit=0", lat, hit); end
  endtask

  task automatic test_random();
    logic nw, hit; logic [3:0] a; int lat, wd, ea, op; logic [47:0] mac;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      if ((op == 0 || op == 3) && m_count > 0) mac = m_tab[$urandom_range(0, m_count - 1)];
      else mac = rand_mac();
      if (op < 2) begin
        drv_chk(mac, hit, a, lat);
        ea = m_find(mac);
        checks++;
        if (lat !== 3 || hit !== (ea >= 0) || (ea >= 0 && a !== 4'(ea))) begin
          errors++; $display("FAIL rnd_chk%0d mac=%h got hit=%b addr=%0d lat=%0d want hit=%b addr=%0d", i, mac, hit, a, lat, ea >= 0, ea);
        end
      end else begin
        drv_lrn(mac, nw, a, lat, wd);
        ea = m_find(mac);
        if (ea >= 0) begin
          checks++;
          if (nw !== 1'b0 || a !== 4'(ea) || wd !== 0) begin
            errors++; $display("FAIL rnd_dup%0d got new=%b addr=%0d we=%0d want new=0 addr=%0d we=0", i, nw, a, wd, ea);
          end
        end else begin
          ea = m_insert(mac);
          checks++;
          if (nw !== 1'b1 || a !== 4'(ea) || wd !== 1) begin
            errors++; $display("FAIL rnd_new%0d got new=%b addr=%0d we=%0d want new=1 addr=%0d we=1", i, nw, a, wd, ea);
          end
        end
        checks++;
        if (entry_count !== 5'(m_count)) begin errors++; $display("FAIL rnd_count%0d got=%0d want=%0d", i, entry_count, m_count); end
      end
    end
  endtask

  initial begin
    m_clear();
    exp_cmp = '0;
    test_reset();
    test_init();
    test_learn_check();
    test_duplicate();
    test_zero_mac();
    test_starvation();
    test_reset_midop();
    test_full_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
